meter_bank: RTL and testbench
=============================

# meter_bank

Multi-bay parking-meter timer: CHANNELS independent seconds counters sharing one tick divider, one coin/preset entry port addressed by a channel select, saturating arithmetic and a per-channel status state machine with blink output. It sits after the button debounce/single-pulse stage and before the seven-segment display driver, replacing the single-bay meter counter.

## Interface
- CHANNELS, 4, number of bays
- CH_W, 2, select width, ≥ clog2(CHANNELS), ≥ 1
- WIDTH, 14, counter width per channel
- MAX_COUNT, 9999, saturation ceiling, < 2^WIDTH
- LOW_THRESH, 200, count below this (and >0) is LOW
- TICK_DIV, 100000000, clk cycles per tick (≥ 2)
- COIN0/1/2/3, 10/180/200/550, amount added by coin[0..3]
- PRESET0/1, 10/205, load values for preset[0]/[1]
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sel  in  CH_W  channel addressed by coin/preset; values ≥ CHANNELS ignored
- coin  in  4  single-cycle pulses, [0]=up [1]=left [2]=right [3]=down
- preset  in  2  single-cycle load pulses
- count  out  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
- state  out  CHANNELS*2  per-channel status code
- blink  out  CHANNELS  display enable per channel
- tick  out  1  one-cycle pulse each tick period

## Operation
- Per-channel update priority, evaluated each clk: preset[0] > preset[1] > coin[0] > coin[1] > coin[2] > coin[3] > tick decrement. Only the highest-priority event acts.
- Preset/coin act only on channel sel; other channels see only tick.
- Coin: count ← min(count + COINk, MAX_COUNT); sum formed in WIDTH+1 bits, never wraps.
- Preset: count ← min(PRESETk, MAX_COUNT).
- Tick: every channel not receiving a preset/coin that cycle with count > 0 decrements by 1; count 0 stays 0 (no underflow).
- Coin/preset on a tick cycle: the addressed channel loses that tick's decrement.
- State (combinational from registered count): EXPIRED (count==0), LOW (0<count<LOW_THRESH), RUN (count ≥ LOW_THRESH).
- Blink: RUN → blink=1 steady. LOW/EXPIRED → blink toggles on every tick (period 2 ticks). On entering LOW or EXPIRED from RUN, blink starts at 1; on entering RUN, blink forced 1 the next cycle.

## Timing
- Reset (async assert, sync-effective release): all counts 0, state EXPIRED, blink 0, divider 0, tick 0.
- Divider counts 0..TICK_DIV-1; tick asserted for the cycle in which divider = TICK_DIV-1; first tick TICK_DIV cycles after reset release.
- count registered: effect of coin/preset/tick visible 1 cycle after the input cycle; state follows in the same cycle as count.
- blink registered: changes 1 cycle after the tick (or state change) that causes it.
- Back-to-back pulses on consecutive cycles each apply; no input handshake, no lost events except lower-priority ones in the same cycle.
- reset_n assertion mid-operation clears immediately regardless of clk.

## Structure
- Package meter_pkg: state codes EXPIRED=2'b00, LOW=2'b01, RUN=2'b10; coin index constants COIN_UP..COIN_DOWN.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset_n, tick): the shared divider. Channel logic in a generate loop inside meter_bank.

## Test plan
- Sim TICK_DIV=4. Reset then sel=1, coin[3] pulse -> count[1]=550 next cycle, state RUN, other channels 0/EXPIRED.
- Channel 0 preset[1] (205), run 6 ticks -> count[0]=199, state LOW on that update, blink toggles each subsequent tick.
- Channel 2 at 9900, coin[1] pulse (+180) -> 9999; further coin[3] -> stays 9999.
- Coin pulse on exact tick cycle for sel=3 at 10 with coin[0] -> 20 (no decrement); other nonzero channels decrement by 1 same cycle.
- preset[0] and coin[3] same cycle -> count=10; coin[0] and coin[2] same cycle -> +10 only; sel=5 (CHANNELS=4) -> no change.
- Channel at 1, one tick -> 0, EXPIRED, further ticks hold 0; reset_n pulsed low mid-divider -> all outputs reset within the same cycle, first tick 4 cycles after release.

Source files
------------

// File: rtl/meter_pkg.sv
// +--------------------------------------------------------------------+
// | meter_pkg : shared status codes and coin indices for meter_bank    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package meter_pkg;

  typedef enum logic [1:0] {
    EXPIRED = 2'b00,
    LOW     = 2'b01,
    RUN     = 2'b10
  } meter_state_e;

  localparam int COIN_UP    = 0;
  localparam int COIN_LEFT  = 1;
  localparam int COIN_RIGHT = 2;
  localparam int COIN_DOWN  = 3;

endpackage

`default_nettype wire

// File: rtl/meter_bank_tick_gen.sv
// +--------------------------------------------------------------------+
// | tick_gen : shared free-running divider, one-cycle tick per period  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (r_div == C_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Decoded from the registered divider so reset clears it asynchronously.
  assign tick = (r_div == C_LAST);

endmodule

`default_nettype wire

// File: rtl/meter_bank.sv
// +--------------------------------------------------------------------+
// | meter_bank : multi-bay parking meter, saturating seconds counters  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module meter_bank
  import meter_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CH_W       = 2,
  parameter int WIDTH      = 14,
  parameter int MAX_COUNT  = 9999,
  parameter int LOW_THRESH = 200,
  parameter int TICK_DIV   = 100000000,
  parameter int COIN0      = 10,
  parameter int COIN1      = 180,
  parameter int COIN2      = 200,
  parameter int COIN3      = 550,
  parameter int PRESET0    = 10,
  parameter int PRESET1    = 205
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CH_W-1:0]           sel,
  input  logic [3:0]                coin,
  input  logic [1:0]                preset,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS*2-1:0]     state,
  output logic [CHANNELS-1:0]       blink,
  output logic                      tick
);

  localparam logic [WIDTH:0]   C_MAX   = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] C_LOW   = WIDTH'(LOW_THRESH);
  localparam logic [WIDTH:0]   C_COIN0 = (WIDTH+1)'(COIN0);
  localparam logic [WIDTH:0]   C_COIN1 = (WIDTH+1)'(COIN1);
  localparam logic [WIDTH:0]   C_COIN2 = (WIDTH+1)'(COIN2);
  localparam logic [WIDTH:0]   C_COIN3 = (WIDTH+1)'(COIN3);
  localparam logic [WIDTH-1:0] C_PRE0  =
    (PRESET0 > MAX_COUNT) ? WIDTH'(MAX_COUNT) : WIDTH'(PRESET0);
  localparam logic [WIDTH-1:0] C_PRE1  =
    (PRESET1 > MAX_COUNT) ? WIDTH'(MAX_COUNT) : WIDTH'(PRESET1);

  logic           w_tick;
  logic           w_sel_ok;
  logic [WIDTH:0] w_add;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign tick     = w_tick;
  assign w_sel_ok = (32'(sel) < 32'(CHANNELS));

  // Only the lowest-numbered coin pulse counts when several arrive together.
  always_comb begin
    w_add = '0;
    if (coin[COIN_UP]) begin
      w_add = C_COIN0;
    end else if (coin[COIN_LEFT]) begin
      w_add = C_COIN1;
    end else if (coin[COIN_RIGHT]) begin
      w_add = C_COIN2;
    end else if (coin[COIN_DOWN]) begin
      w_add = C_COIN3;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic             r_blink;
    logic             w_hit;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_sat;
    logic [WIDTH-1:0] w_next;
    meter_state_e     w_state;

    assign w_hit = w_sel_ok && (sel == CH_W'(i));
    assign w_sum = {1'b0, r_count} + w_add;
    assign w_sat = (w_sum > C_MAX) ? C_MAX[WIDTH-1:0] : w_sum[WIDTH-1:0];

    always_comb begin
      w_next = r_count;
      if (w_hit && preset[0]) begin
        w_next = C_PRE0;
      end else if (w_hit && preset[1]) begin
        w_next = C_PRE1;
      end else if (w_hit && (|coin)) begin
        w_next = w_sat;
      end else if (w_tick && (r_count != '0)) begin
        w_next = r_count - WIDTH'(1);
      end
    end

    always_comb begin
      w_state = RUN;
      if (r_count == '0) begin
        w_state = EXPIRED;
      end else if (r_count < C_LOW) begin
        w_state = LOW;
      end
    end

    // Held high while running, so LOW/EXPIRED always begin blinking from 1.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_count <= '0;
        r_blink <= 1'b0;
      end else begin
        r_count <= w_next;
        if (w_state == RUN) begin
          r_blink <= 1'b1;
        end else if (w_tick) begin
          r_blink <= ~r_blink;
        end
      end
    end

    assign count[i*WIDTH +: WIDTH] = r_count;
    assign state[2*i +: 2]         = w_state;
    assign blink[i]                = r_blink;
  end

endmodule

`default_nettype wire

// File: tb/tb_meter_bank.sv
// +--------------------------------------------------------------------+
// | tb_meter_bank : directed + random bench against a cycle model      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_meter_bank;

  localparam int CHANNELS = 4;
  localparam int CH_W     = 3;
  localparam int WIDTH    = 14;
  localparam int MAXC     = 9999;
  localparam int LOWT     = 200;
  localparam int TDIV     = 4;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [CH_W-1:0]           sel = '0;
  logic [3:0]                coin = '0;
  logic [1:0]                preset = '0;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS*2-1:0]     state;
  logic [CHANNELS-1:0]       blink;
  logic                      tick;

  int n_assert = 0;
  int n_fail   = 0;

  int coin_val [4] = '{10, 180, 200, 550};
  int m_count [CHANNELS];
  int m_blink [CHANNELS];
  int m_cyc;

  meter_bank #(
    .CHANNELS   (CHANNELS),
    .CH_W       (CH_W),
    .WIDTH      (WIDTH),
    .MAX_COUNT  (MAXC),
    .LOW_THRESH (LOWT),
    .TICK_DIV   (TDIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sel     (sel),
    .coin    (coin),
    .preset  (preset),
    .count   (count),
    .state   (state),
    .blink   (blink),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int st_of(input int c);
    if (c == 0) return 0;
    if (c < LOWT) return 1;
    return 2;
  endfunction

  task automatic chk_all(input string tag);
    for (int i = 0; i < CHANNELS; i++) begin
      chk($sformatf("%s cnt%0d", tag, i), 32'(count[i*WIDTH +: WIDTH]), 32'(m_count[i]));
      chk($sformatf("%s st%0d", tag, i), 32'(state[2*i +: 2]), 32'(st_of(m_count[i])));
      chk($sformatf("%s bl%0d", tag, i), 32'(blink[i]), 32'(m_blink[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_count[i] = 0;
      m_blink[i] = 0;
    end
    m_cyc = 0;
  endtask

  // Drive one cycle of inputs, check tick, clock, then check every channel.
  task automatic cyc(input int s, input logic [3:0] c, input logic [1:0] p);
    bit tk;
    int amt;
    sel    = CH_W'(s);
    coin   = c;
    preset = p;
    tk = ((m_cyc % TDIV) == TDIV - 1);
    chk("tick", 32'(tick), 32'(tk));
    for (int i = 0; i < CHANNELS; i++) begin
      if (m_count[i] >= LOWT) m_blink[i] = 1;
      else if (tk) m_blink[i] = 1 - m_blink[i];
      if (i == s && p[0]) begin
        m_count[i] = 10;
      end else if (i == s && p[1]) begin
        m_count[i] = 205;
      end else if (i == s && c != 0) begin
        amt = 0;
        for (int k = 3; k >= 0; k--) if (c[k]) amt = coin_val[k];
        m_count[i] = (m_count[i] + amt > MAXC) ? MAXC : m_count[i] + amt;
      end else if (tk && m_count[i] > 0) begin
        m_count[i] = m_count[i] - 1;
      end
    end
    @(posedge clk);
    #1;
    m_cyc++;
    coin   = '0;
    preset = '0;
    chk_all("step");
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(0, 4'b0000, 2'b00);
  endtask

  task automatic align(input int phase);
    for (int j = 0; j < TDIV && (m_cyc % TDIV) != phase; j++) idle(1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset tick", 32'(tick), 32'd0);
    reset_n = 1'b1;

    // Down coin on bay 1
    cyc(1, 4'b1000, 2'b00);
    chk("bay1 550", 32'(count[1*WIDTH +: WIDTH]), 32'd550);
    chk("bay1 RUN", 32'(state[3:2]), 32'd2);

    // Bay 0 preset 205 and countdown into LOW with blinking
    cyc(0, 4'b0000, 2'b10);
    idle(30);

    // Bay 2 toward saturation
    for (int j = 0; j < 18; j++) cyc(2, 4'b1000, 2'b00);
    cyc(2, 4'b0010, 2'b00);
    cyc(2, 4'b1000, 2'b00);
    chk("bay2 sat", 32'(count[2*WIDTH +: WIDTH]), 32'd9999);

    // Coin on the exact tick cycle
    align(TDIV - 2);
    cyc(3, 4'b0000, 2'b01);
    cyc(3, 4'b0001, 2'b00);
    chk("bay3 no dec", 32'(count[3*WIDTH +: WIDTH]), 32'd20);

    // Same-cycle priority and out-of-range select
    cyc(0, 4'b1000, 2'b01);
    chk("pre beats coin", 32'(count[0 +: WIDTH]), 32'd10);
    cyc(0, 4'b0101, 2'b00);
    cyc(5, 4'b1000, 2'b11);
    cyc(7, 4'b0001, 2'b00);

    // Countdown to EXPIRED and hold
    cyc(0, 4'b0000, 2'b01);
    idle(60);
    chk("bay0 expired", 32'(state[1:0]), 32'd0);

    // Asynchronous reset mid-divider
    align(1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("async rst");
    chk("async rst tick", 32'(tick), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(TDIV + 1);

    // Random traffic
    for (int j = 0; j < 400; j++) begin
      logic [3:0] c;
      logic [1:0] p;
      c = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      p = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      cyc(int'($urandom_range(0, 7)), c, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
